// File: rtl/cam_readout_if.sv
// cam_readout_if -- record stream from the CAM readout block to the
// redundancy-analysis / repair-allocation logic.
//
// Handshake: a record transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid is raised the producer keeps
// out_type/out_idx/out_data stable and out_valid high until that transfer;
// out_ready may change freely and never depends combinationally on out_valid.
interface cam_readout_if #(
    parameter int IDXW = 4
);
    logic            out_valid;
    logic            out_ready;
    logic            out_type;   // 0 = pivot record, 1 = non-pivot record
    logic [IDXW-1:0] out_idx;    // source entry index inside its CAM
    logic [25:0]     out_data;   // pivot entry, or {9'b0, non-pivot entry}

    modport master (
        output out_valid,
        output out_type,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_type,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/cam_readout.sv
// cam_readout -- snapshots the pivot and non-pivot fault CAMs on a start pulse
// and streams the entries, lowest index first, pivot entries before non-pivot
// entries, one record per accepted handshake.
//
// Build option CAM_RD_SKIP_EN:
//   defined   -> entries whose enable bit is 0 are skipped
//   undefined -> every entry is emitted; the enable bit is visible in out_data
//
// Pivot entry   (26b): {enable, row[9:0], col[9:0], bnk[1:0], must[2:0]}
// Non-pivot entry (17b): {enable, ptr[2:0], dscrpt, addr[9:0], bnk[1:0]}
module cam_readout #(
    parameter int PCAM  = 8,
    parameter int NPCAM = 16,
    parameter int IDXW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active low
    input  logic                 start,
    input  logic [PCAM*26-1:0]   pcam_bus,
    input  logic [NPCAM*17-1:0]  npcam_bus,
    cam_readout_if.master        out_if,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           rec_cnt,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PIV  = 2'd1,
        S_NPIV = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               state;

    // Snapshot of both CAMs taken at start; the live buses are free to change.
    logic [PCAM*26-1:0]   pcam_sh;
    logic [NPCAM*17-1:0]  npcam_sh;

    // Entries still to be emitted.
    logic [PCAM-1:0]      pmask;
    logic [NPCAM-1:0]     nmask;

    // Initial masks derived from the live buses at start.
    logic [PCAM-1:0]      p_init;
    logic [NPCAM-1:0]     n_init;

    // Lowest pending entry of each CAM.
    logic [PCAM-1:0]      p_low;
    logic [NPCAM-1:0]     n_low;
    logic [IDXW-1:0]      p_sel_idx;
    logic [IDXW-1:0]      n_sel_idx;
    logic [25:0]          p_sel_data;
    logic [16:0]          n_sel_data;

    logic                 accept;
    logic                 slot_free;

    assign state_dbg = state;

    // A record leaves on this edge; the output register can take a new one
    // when it is empty or being drained in the same cycle.
    assign accept    = out_if.out_valid & out_if.out_ready;
    assign slot_free = ~out_if.out_valid | out_if.out_ready;

    // Isolate the lowest pending bit of each mask (x & -x).
    assign p_low = pmask & (~pmask + PCAM'(1));
    assign n_low = nmask & (~nmask + NPCAM'(1));

    // Build the starting masks from the enable bits, or take every entry.
    always_comb begin
        p_init = '0;
        n_init = '0;
`ifdef CAM_RD_SKIP_EN
        for (int i = 0; i < PCAM; i++) begin
            p_init[i] = pcam_bus[26*i+25];
        end
        for (int j = 0; j < NPCAM; j++) begin
            n_init[j] = npcam_bus[17*j+16];
        end
`else
        p_init = '1;
        n_init = '1;
`endif
    end

    // Lowest-index pending pivot entry: scan downward so the lowest wins.
    always_comb begin
        p_sel_idx  = '0;
        p_sel_data = '0;
        for (int i = PCAM - 1; i >= 0; i--) begin
            if (pmask[i]) begin
                p_sel_idx  = IDXW'(i);
                p_sel_data = pcam_sh[26*i +: 26];
            end
        end
    end

    // Lowest-index pending non-pivot entry.
    always_comb begin
        n_sel_idx  = '0;
        n_sel_data = '0;
        for (int j = NPCAM - 1; j >= 0; j--) begin
            if (nmask[j]) begin
                n_sel_idx  = IDXW'(j);
                n_sel_data = npcam_sh[17*j +: 17];
            end
        end
    end

    // Readout FSM with registered stream, status and snapshot registers.
    // PIV and NPIV share one loader: pivot entries drain first, and when the
    // pivot mask is empty the next free slot takes a non-pivot entry, so the
    // changeover costs no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            pcam_sh           <= '0;
            npcam_sh          <= '0;
            pmask             <= '0;
            nmask             <= '0;
            out_if.out_valid  <= 1'b0;
            out_if.out_type   <= 1'b0;
            out_if.out_idx    <= '0;
            out_if.out_data   <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            rec_cnt           <= '0;
        end else begin
            done <= 1'b0;

            if (accept && rec_cnt != 5'd31) begin
                rec_cnt <= rec_cnt + 5'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        pcam_sh  <= pcam_bus;
                        npcam_sh <= npcam_bus;
                        pmask    <= p_init;
                        nmask    <= n_init;
                        rec_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_PIV;
                    end
                end

                S_PIV, S_NPIV: begin
                    if (slot_free) begin
                        if (|pmask) begin
                            out_if.out_valid <= 1'b1;
                            out_if.out_type  <= 1'b0;
                            out_if.out_idx   <= p_sel_idx;
                            out_if.out_data  <= p_sel_data;
                            pmask            <= pmask & ~p_low;
                            state            <= S_PIV;
                        end else if (|nmask) begin
                            out_if.out_valid <= 1'b1;
                            out_if.out_type  <= 1'b1;
                            out_if.out_idx   <= n_sel_idx;
                            out_if.out_data  <= {9'b0, n_sel_data};
                            nmask            <= nmask & ~n_low;
                            state            <= S_NPIV;
                        end else begin
                            out_if.out_valid <= 1'b0;
                            state            <= S_FIN;
                        end
                    end
                end

                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_readout.sv
// tb_cam_readout -- randomized scoreboard bench for cam_readout.
// Expected records come from a list model of the snapshot; a negedge monitor
// pops and compares every accepted record and watches hold-under-stall.
`timescale 1ns/1ps
module tb_cam_readout;

  localparam int PCAM  = 8;
  localparam int NPCAM = 16;
  localparam int IDXW  = 4;
  localparam int W     = 1 + IDXW + 26;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic [PCAM*26-1:0]   pcam_bus = '0;
  logic [NPCAM*17-1:0]  npcam_bus = '0;
  logic                 busy;
  logic                 done;
  logic [4:0]           rec_cnt;
  logic [1:0]           state_dbg;

  cam_readout_if #(.IDXW(IDXW)) out_if ();

  cam_readout #(.PCAM(PCAM), .NPCAM(NPCAM), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pcam_bus  (pcam_bus),
    .npcam_bus (npcam_bus),
    .out_if    (out_if),
    .busy      (busy),
    .done      (done),
    .rec_cnt   (rec_cnt),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit keep_entry(input logic en);
`ifdef CAM_RD_SKIP_EN
    return en;
`else
    return 1'b1;
`endif
  endfunction

  // Walk the current bus contents (the snapshot the DUT will take) in emission order.
  task automatic expect_stream(output int n);
    logic [25:0] pe;
    logic [16:0] ne;
    n = 0;
    for (int i = 0; i < PCAM; i++) begin
      pe = pcam_bus[26*i +: 26];
      if (keep_entry(pe[25])) begin
        exp_q.push_back({1'b0, IDXW'(i), pe});
        n++;
      end
    end
    for (int j = 0; j < NPCAM; j++) begin
      ne = npcam_bus[17*j +: 17];
      if (keep_entry(ne[16])) begin
        exp_q.push_back({1'b1, IDXW'(j), {9'b0, ne}});
        n++;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         stall_q = 1'b0;
  logic [W-1:0] held    = '0;

  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    if (!rst) begin
      stall_q = 1'b0;
    end else begin
      cur = {out_if.out_type, out_if.out_idx, out_if.out_data};
      if (done) done_cnt++;
      if (stall_q) check("hold_under_stall", {out_if.out_valid, cur}, {1'b1, held});
      if (out_if.out_valid && out_if.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL record_unexpected actual=%0h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          check("record", {1'b0, cur}, {1'b0, e});
        end
        acc_cnt++;
      end
      stall_q = out_if.out_valid && !out_if.out_ready;
      held    = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic random_buses(input int en_pct);
    logic [25:0] pe;
    logic [16:0] ne;
    for (int i = 0; i < PCAM; i++) begin
      pe = 26'($urandom);
      pe[25] = ($urandom_range(0, 99) < en_pct);
      pcam_bus[26*i +: 26] = pe;
    end
    for (int j = 0; j < NPCAM; j++) begin
      ne = 17'($urandom);
      ne[16] = ($urandom_range(0, 99) < en_pct);
      npcam_bus[17*j +: 17] = ne;
    end
  endtask

  // mode 0: ready always 1; mode 1: ready low 5 cycles after first valid;
  // mode 2: random ready. A start pulse is also issued while busy.
  task automatic run(input string tag, input int mode);
    int n, cnt, done_at, base_done, exp_done;
    expect_stream(n);
    base_done = done_cnt;
    out_if.out_ready = 1'b1;
    start = 1'b1;
    tick();                       // edge N taken
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_no_valid_at_N"}, out_if.out_valid, 0);
    cnt = 0;
    done_at = -1;
    while (cnt < 300 && done_at < 0) begin
      if (cnt == 0) begin
        pcam_bus  = ~pcam_bus;    // live CAM keeps changing after the snapshot
        npcam_bus = ~npcam_bus;
      end
      start = (cnt == 1);
      case (mode)
        1:       out_if.out_ready = !(cnt >= 1 && cnt <= 5);
        2:       out_if.out_ready = ($urandom_range(0, 3) != 0);
        default: out_if.out_ready = 1'b1;
      endcase
      tick();
      cnt++;
      if (cnt == 1) check({tag, "_first_valid"}, out_if.out_valid, (n > 0));
      if (done) done_at = cnt;
    end
    start = 1'b0;
    out_if.out_ready = 1'b1;
    if (mode == 2) begin
      check({tag, "_done_seen"}, (done_at > 0), 1);
    end else begin
      exp_done = (mode == 1 && n > 0) ? 7 + n : 2 + n;
      check({tag, "_done_edge"}, done_at, exp_done);
    end
    repeat (4) tick();
    check({tag, "_done_pulses"}, done_cnt - base_done, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_rec_cnt"}, rec_cnt, (n > 31) ? 31 : n);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_idle_state"}, state_dbg, 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_stream();
    int n, k, base_acc, base_done, vseen;
    random_buses(100);
    expect_stream(n);
    base_acc  = acc_cnt;
    base_done = done_cnt;
    out_if.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (acc_cnt - base_acc < 5 && k < 50) begin
      tick();
      k++;
    end
    check("rst_reached_record5", (acc_cnt - base_acc >= 5), 1);
    #2 rst = 1'b0;                // asynchronous, mid-cycle
    #1;
    check("rst_out_valid", out_if.out_valid, 0);
    check("rst_out_fields", {out_if.out_type, out_if.out_idx, out_if.out_data}, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_rec_cnt", rec_cnt, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    vseen = 0;
    repeat (8) begin
      tick();
      if (out_if.out_valid || done) vseen++;
    end
    check("rst_no_activity_after", vseen, 0);
    check("rst_no_done", done_cnt - base_done, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [25:0] p0, p2;
    logic [16:0] n1;
    out_if.out_ready = 1'b0;
    #1;
    check("reset_valid", out_if.out_valid, 0);
    check("reset_fields", {out_if.out_type, out_if.out_idx, out_if.out_data}, 0);
    check("reset_status", {busy, done, rec_cnt}, 0);
    tick();
    rst = 1'b1;
    repeat (5) begin
      tick();
      check("idle_no_valid", out_if.out_valid, 0);
    end

    // basic stream: pivots 0 and 2, non-pivot 1
    p0 = {1'b1, 10'h005, 10'h003, 2'b01, 3'b000};
    p2 = {1'b1, 10'h0a1, 10'h132, 2'b11, 3'b101};
    n1 = {1'b1, 3'd0, 1'b0, 10'h005, 2'b10};
    pcam_bus = '0;
    npcam_bus = '0;
    pcam_bus[26*0 +: 26] = p0;
    pcam_bus[26*2 +: 26] = p2;
    npcam_bus[17*1 +: 17] = n1;
    run("basic", 0);

    // same setup under backpressure
    pcam_bus = '0;
    npcam_bus = '0;
    pcam_bus[26*0 +: 26] = p0;
    pcam_bus[26*2 +: 26] = p2;
    npcam_bus[17*1 +: 17] = n1;
    run("backpressure", 1);

    // empty CAM
    pcam_bus = '0;
    npcam_bus = '0;
    run("empty", 0);

    // randomized contents and ready patterns
    for (int r = 0; r < 6; r++) begin
      random_buses($urandom_range(0, 100));
      run("random", (r % 3 == 0) ? 1 : 2);
    end

    reset_mid_stream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cam_readout.md
Name: cam_readout

Overview:
- Reader on the far side of the fault CAM. On a start pulse it snapshots the pivot and non-pivot CAM contents.
- It then streams the entries, one per handshake, to the downstream redundancy-analysis/repair-allocation logic: all pivot entries first, then all non-pivot entries.
- Because the CAM is snapshotted, fault collection may continue while readout proceeds.

Parameters:
- PCAM, 8, number of pivot CAM entries (non-pivot pointer is 3 bits, so PCAM <= 8)
- NPCAM, 16, number of non-pivot CAM entries
- IDXW, 4, index width of out_idx; must satisfy 2^IDXW >= max(PCAM, NPCAM)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; snapshot CAM and begin readout
- pcam_bus  in  PCAM*26  pivot entries; entry i at [26i+25:26i] = {enable, row[9:0], col[9:0], bnk[1:0], must[2:0]}
- npcam_bus  in  NPCAM*17  non-pivot entries; entry j at [17j+16:17j] = {enable, ptr[2:0], dscrpt, addr[9:0], bnk[1:0]}
- out_valid  out  1  record valid
- out_ready  in  1  downstream accept
- out_type  out  1  0 = pivot record, 1 = non-pivot record
- out_idx  out  IDXW  source entry index
- out_data  out  26  pivot: full 26-bit entry; non-pivot: {9'b0, 17-bit entry}
- busy  out  1  high from the start acceptance edge until the done edge
- done  out  1  one-cycle pulse after the last record is accepted
- rec_cnt  out  5  records emitted in the last or current readout; saturates at 31

Behaviour:
- Reset (rst low, asynchronous): state IDLE; out_valid, busy, done = 0; out_type, out_idx, out_data, rec_cnt = 0; shadow registers and remaining-masks = 0.
- FSM states: IDLE, PIV, NPIV, FIN.
- IDLE:
  - start=1 at edge N: capture pcam_bus and npcam_bus into shadow registers.
  - Pivot mask = enabled pivot entries; non-pivot mask = enabled non-pivot entries.
  - rec_cnt <= 0, busy <= 1, go to PIV.
  - start while not IDLE is ignored.
- PIV:
  - With an empty output register or a handshake this cycle (out_valid & out_ready): load the lowest-index set bit of the pivot mask into out_*, set out_valid, clear that mask bit.
  - When the pivot mask is empty, go to NPIV with no bubble; the first non-pivot record loads in the same cycle the last pivot record is accepted.
- NPIV: same mechanism over the non-pivot mask. When that mask is empty and the output register is empty or being accepted, go to FIN and drop out_valid.
- FIN: done <= 1 for one cycle, busy <= 0, return to IDLE. start in FIN is ignored.
- Latency: start at edge N gives the first out_valid after edge N+1. Sustained throughput is one record per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_type, out_idx and out_data hold stable.
- rec_cnt increments on each accepted record and saturates at 31; the value holds after done until the next start.
- Empty snapshot (no enabled entries): no out_valid; done pulses after edge N+2.
- Snapshot isolation: changes on pcam_bus/npcam_bus after edge N do not affect the stream.
- Reset mid-readout: immediate return to IDLE with all outputs 0; no done pulse.

Optional Feature:
- CAM_RD_SKIP_EN
- Defined: disabled entries (enable=0) are skipped, as described above.
- Undefined: both masks initialise to all-ones, every entry 0..PCAM-1 then 0..NPCAM-1 is emitted including disabled ones (enable bit visible in out_data), and rec_cnt reaches min(PCAM+NPCAM, 31).

Test Plan:
- Reset check: hold rst low mid-cycle (asynchronous) -> all outputs 0 immediately; release, no start -> out_valid stays 0.
- Basic stream, SKIP_EN defined: pivot 0 = {1, row 10'h005, col 10'h003, bnk 2'b01, must 3'b000} and pivot 2 enabled; non-pivot 1 = {1, ptr 3'd0, dscrpt 0, addr 10'h005, bnk 2'b10}; out_ready=1; start -> records (0,0), (0,2), (1,1) on consecutive cycles, then done; rec_cnt=3.
- Backpressure: same setup, out_ready low for 5 cycles after first valid -> record (0,0) held unchanged; order and count preserved.
- Snapshot isolation: change pcam_bus entry 2 one cycle after start -> emitted (0,2) data equals the pre-change value.
- Empty CAM: all enables 0, start -> no valid; done 2 edges after start; rec_cnt=0. Start pulsed while busy -> ignored, no second done.
- SKIP_EN undefined: same stimulus as the basic stream -> 24 records (8 pivot + 16 non-pivot), disabled ones with bit 25 / bit 16 = 0; rec_cnt=24. Reset at record 5 -> outputs 0, no done.
